// File: rtl/mem_read_responder.sv
// Memory-side read responder: buffers tagged read requests in order and
// returns multi-beat bursts from an internal word array after a fixed latency.
module mem_read_responder #(
  parameter int DataWidth    = 64,
  parameter int AddrWidth    = 64,
  parameter int TidWidth     = 4,
  parameter int LenWidth     = 2,
  parameter int MemWords     = 1024,
  parameter int ReqFifoDepth = 2,
  parameter int Latency      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic [TidWidth-1:0]         req_tid_i,
  input  logic [LenWidth-1:0]         req_len_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [DataWidth-1:0]        resp_data_o,
  output logic [TidWidth-1:0]         resp_tid_o,
  output logic                        resp_last_o,
  output logic                        resp_error_o,
  input  logic                        bd_we_i,
  input  logic [$clog2(MemWords)-1:0] bd_addr_i,
  input  logic [DataWidth-1:0]        bd_data_i
);

  localparam int ByteOff = $clog2(DataWidth / 8);
  localparam int MemAw   = $clog2(MemWords);
  localparam int WordW   = AddrWidth - ByteOff;
  localparam int PtrW    = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int CntW    = $clog2(ReqFifoDepth + 1);
  localparam int LatW    = (Latency > 1) ? $clog2(Latency + 1) : 1;
  localparam int EntW    = WordW + TidWidth + LenWidth;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_e;

  // Request FIFO stores the word address, so the byte-offset bits are dropped here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[ByteOff-1:0];

  logic [EntW-1:0]      fifo_q [ReqFifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 push, pop, fifo_nempty;
  logic [EntW-1:0]      head;
  logic [WordW-1:0]     h_word;
  logic [TidWidth-1:0]  h_tid;
  logic [LenWidth-1:0]  h_len;

  logic [DataWidth-1:0] mem_q [MemWords];

  state_e               state_q, state_d;
  logic [LatW-1:0]      lat_q, lat_d;
  logic [WordW-1:0]     base_q, base_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  idx_q, idx_d;
  logic [TidWidth-1:0]  tid_q, tid_d;

  logic                 resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0] resp_data_q, resp_data_d;
  logic [TidWidth-1:0]  resp_tid_q, resp_tid_d;
  logic                 resp_last_q, resp_last_d;
  logic                 resp_error_q, resp_error_d;

  logic [WordW:0]       word_sum;
  logic                 in_range;
  logic [MemAw-1:0]     mem_idx;
  logic [DataWidth-1:0] rd_word;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(ReqFifoDepth - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign req_ready_o = (count_q != CntW'(ReqFifoDepth));
  assign push        = req_valid_i && req_ready_o;
  assign fifo_nempty = (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign h_word      = head[EntW-1 -: WordW];
  assign h_tid       = head[LenWidth +: TidWidth];
  assign h_len       = head[LenWidth-1:0];

  // FIFO payload storage; contents need no reset, occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {req_addr_i[AddrWidth-1:ByteOff], req_tid_i, req_len_i};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Backdoor preload port; writes are blocked while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (rst_ni && bd_we_i) mem_q[bd_addr_i] <= bd_data_i;
  end

  // FSM state, burst context and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      base_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      tid_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tid_q   <= '0;
      resp_last_q  <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      base_q       <= base_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      tid_q        <= tid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tid_q   <= resp_tid_d;
      resp_last_q  <= resp_last_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Next-state logic: pop in IDLE, count down the latency, step through beats.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tid_d   = tid_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_nempty) begin
          pop    = 1'b1;
          base_d = h_word;
          len_d  = h_len;
          tid_d  = h_tid;
          idx_d  = '0;
          // Outputs are registered, so a latency of 1 already costs the pop cycle.
          if (Latency <= 1) begin
            state_d = S_BURST;
          end else begin
            state_d = S_WAIT;
            lat_d   = LatW'(Latency);
          end
        end
      end
      S_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q <= LatW'(2)) state_d = S_BURST;
      end
      S_BURST: begin
        if (resp_valid_q && resp_ready_i) begin
          if (idx_q == len_q) state_d = S_IDLE;
          else                idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next beat contents, with same-cycle backdoor writes forwarded.
  always_comb begin
    word_sum     = {1'b0, base_d} + (WordW + 1)'(idx_d);
    in_range     = (word_sum < (WordW + 1)'(MemWords));
    mem_idx      = word_sum[MemAw-1:0];
    rd_word      = (bd_we_i && (bd_addr_i == mem_idx)) ? bd_data_i : mem_q[mem_idx];
    resp_valid_d = (state_d == S_BURST);
    resp_data_d  = (resp_valid_d && in_range) ? rd_word : '0;
    resp_error_d = resp_valid_d && !in_range;
    resp_last_d  = resp_valid_d && (idx_d == len_d);
    resp_tid_d   = resp_valid_d ? tid_d : '0;
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_tid_o   = resp_tid_q;
  assign resp_last_o  = resp_last_q;
  assign resp_error_o = resp_error_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: scoreboard model plus directed scenarios.
module tb_mem_read_responder;
  localparam int DW = 64;
  localparam int MW = 1024;
  localparam int LAT0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni;
  logic          req_valid, req_ready, resp_valid, resp_ready, resp_last, resp_error, bd_we;
  logic [63:0]   req_addr;
  logic [3:0]    req_tid, resp_tid;
  logic [1:0]    req_len;
  logic [DW-1:0] resp_data, bd_data;
  logic [9:0]    bd_addr;

  logic          req_valid1, req_ready1, resp_valid1, resp_ready1, resp_last1, resp_error1, bd_we1;
  logic [63:0]   req_addr1;
  logic [3:0]    req_tid1, resp_tid1;
  logic [1:0]    req_len1;
  logic [DW-1:0] resp_data1, bd_data1;
  logic [9:0]    bd_addr1;

  mem_read_responder #(.DataWidth(64), .AddrWidth(64), .TidWidth(4), .LenWidth(2),
    .MemWords(MW), .ReqFifoDepth(2), .Latency(LAT0)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_tid_i(req_tid), .req_len_i(req_len),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_tid_o(resp_tid), .resp_last_o(resp_last), .resp_error_o(resp_error),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_data_i(bd_data));

  mem_read_responder #(.DataWidth(64), .AddrWidth(64), .TidWidth(4), .LenWidth(2),
    .MemWords(MW), .ReqFifoDepth(2), .Latency(0)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_addr_i(req_addr1), .req_tid_i(req_tid1), .req_len_i(req_len1),
    .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1), .resp_data_o(resp_data1),
    .resp_tid_o(resp_tid1), .resp_last_o(resp_last1), .resp_error_o(resp_error1),
    .bd_we_i(bd_we1), .bd_addr_i(bd_addr1), .bd_data_i(bd_data1));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle=%0d limit=60000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model for u0 ----------------
  typedef struct {
    logic [63:0] word;
    logic [3:0]  tid;
    int          len;
    int          acc;
  } req_t;

  req_t        mq[$];
  logic [63:0] mmem [MW];
  int          h_start = 0;
  int          h_beat = 0;
  int          prev_end = -100;

  // A request leaves the FIFO once it has been there a cycle and the responder
  // is idle (the cycle after the previous burst's last handshake).
  function automatic int start_of(input int acc, input int pend);
    int p;
    p = (acc + 1 > pend + 1) ? acc + 1 : pend + 1;
    return p + LAT0;
  endfunction

  always @(negedge clk) begin
    logic [63:0] w;
    logic        ev;
    int          n;
    req_t        r;
    if (!rst_ni) begin
      mq.delete();
      prev_end = -100;
      h_beat = 0;
    end else begin
      ev = (mq.size() > 0) && (cyc >= h_start);
      check("resp_valid", resp_valid, ev);
      if (ev) begin
        w = mq[0].word + 64'(h_beat);
        check("resp_tid", resp_tid, mq[0].tid);
        check("resp_last", resp_last, h_beat == mq[0].len);
        check("resp_error", resp_error, w >= MW);
        check("resp_data", resp_data, (w < MW) ? mmem[w[9:0]] : 64'd0);
      end
      n = 0;
      foreach (mq[k]) if (mq[k].acc < cyc && (k > 0 || cyc <= h_start - LAT0)) n++;
      check("req_ready", req_ready, n < 2);
      if (ev && resp_valid && resp_ready) begin
        if (h_beat == mq[0].len) begin
          prev_end = cyc;
          void'(mq.pop_front());
          h_beat = 0;
          if (mq.size() > 0) h_start = start_of(mq[0].acc, prev_end);
        end else begin
          h_beat++;
        end
      end
      if (req_valid && req_ready) begin
        r.word = req_addr >> 3;
        r.tid = req_tid;
        r.len = int'(req_len);
        r.acc = cyc;
        mq.push_back(r);
        if (mq.size() == 1) h_start = start_of(cyc, prev_end);
      end
      if (bd_we) mmem[bd_addr] = bd_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [3:0] t, input logic [1:0] l);
    bit acc;
    int k;
    acc = 0;
    k = 0;
    req_valid = 1'b1;
    req_addr = a;
    req_tid = t;
    req_len = l;
    while (!acc && k < 100) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      k++;
    end
    req_valid = 1'b0;
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!resp_valid && k < 40) begin
      tick();
      k++;
    end
    check("wait_valid", resp_valid, 1'b1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((mq.size() != 0 || resp_valid) && k < 300) begin
      tick();
      k++;
    end
    check("drain", (mq.size() == 0) && !resp_valid, 1'b1);
  endtask

  initial begin
    bit acc;
    rst_ni = 1'b0;
    req_valid = 0; req_addr = '0; req_tid = '0; req_len = '0; resp_ready = 0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    req_valid1 = 0; req_addr1 = '0; req_tid1 = '0; req_len1 = '0; resp_ready1 = 0;
    bd_we1 = 0; bd_addr1 = '0; bd_data1 = '0;
    repeat (3) tick();
    rst_ni = 1'b1;
    check("rst_valid", resp_valid, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_data", resp_data, 64'd0);
    check("rst_tid", resp_tid, 64'd0);
    check("rst_last", resp_last, 1'b0);
    check("rst_error", resp_error, 1'b0);

    // preload the whole array, then pin a few words
    for (int i = 0; i < MW; i++) begin
      bd_we = 1'b1; bd_addr = 10'(i); bd_data = {$urandom, $urandom};
      tick();
    end
    bd_addr = 10'd4;    bd_data = 64'hA;         tick();
    bd_addr = 10'd5;    bd_data = 64'hB;         tick();
    bd_addr = 10'd1023; bd_data = 64'h1234_5678; tick();
    bd_we = 1'b0;
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;

    // single burst, exact latency
    resp_ready = 1'b1;
    send(64'h20, 4'd3, 2'd1);
    check("t1_wait0", resp_valid, 1'b0);
    tick(); check("t1_wait1", resp_valid, 1'b0);
    tick();
    check("t1_b0_valid", resp_valid, 1'b1);
    check("t1_b0_data", resp_data, 64'hA);
    check("t1_b0_tid", resp_tid, 64'd3);
    check("t1_b0_last", resp_last, 1'b0);
    tick();
    check("t1_b1_data", resp_data, 64'hB);
    check("t1_b1_last", resp_last, 1'b1);
    check("t1_b1_error", resp_error, 1'b0);
    tick(); check("t1_after", resp_valid, 1'b0);

    // backpressure on beat 0
    resp_ready = 1'b0;
    send(64'h20, 4'd3, 2'd1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_data", resp_data, 64'hA);
      check("t2_hold_last", resp_last, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("t2_b1_data", resp_data, 64'hB);
    check("t2_b1_last", resp_last, 1'b1);
    wait_drain();

    // FIFO fills while the responder is stalled
    resp_ready = 1'b0;
    send(64'h0, 4'd0, 2'd0);
    send(64'h8, 4'd1, 2'd1);
    send(64'h10, 4'd2, 2'd0);
    check("t3_full", req_ready, 1'b0);
    fork
      send(64'h18, 4'd3, 2'd2);
      begin repeat (4) tick(); resp_ready = 1'b1; end
    join
    wait_drain();

    // out of range inside a burst
    send(64'd1023 * 8, 4'd9, 2'd1);
    wait_valid();
    check("t4_b0_error", resp_error, 1'b0);
    check("t4_b0_data", resp_data, 64'h1234_5678);
    tick();
    check("t4_b1_error", resp_error, 1'b1);
    check("t4_b1_data", resp_data, 64'd0);
    check("t4_b1_last", resp_last, 1'b1);
    wait_drain();

    // reset mid-burst with a request queued
    resp_ready = 1'b0;
    send(64'h40, 4'd7, 2'd3);
    send(64'h48, 4'd8, 2'd0);
    wait_valid();
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    check("t5_valid", resp_valid, 1'b0);
    check("t5_ready", req_ready, 1'b1);
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_quiet", resp_valid, 1'b0);
    end

    // Latency=0 instance and backdoor race on a held beat
    bd_we1 = 1'b1; bd_addr1 = 10'd0; bd_data1 = 64'h1111; tick();
    bd_addr1 = 10'd1; bd_data1 = 64'h3333; tick();
    bd_we1 = 1'b0;
    resp_ready1 = 1'b0;
    req_valid1 = 1'b1; req_addr1 = 64'h0; req_tid1 = 4'd5; req_len1 = 2'd1;
    check("t6_ready", req_ready1, 1'b1);
    tick(); req_valid1 = 1'b0;
    check("t6_pop", resp_valid1, 1'b0);
    tick();
    check("t6_b0_valid", resp_valid1, 1'b1);
    check("t6_b0_data", resp_data1, 64'h1111);
    check("t6_b0_tid", resp_tid1, 64'd5);
    bd_we1 = 1'b1; bd_addr1 = 10'd0; bd_data1 = 64'h2222;
    tick(); bd_we1 = 1'b0;
    check("t6_race_data", resp_data1, 64'h2222);
    check("t6_race_valid", resp_valid1, 1'b1);
    check("t6_race_last", resp_last1, 1'b0);
    resp_ready1 = 1'b1;
    tick();
    check("t6_b1_data", resp_data1, 64'h3333);
    check("t6_b1_last", resp_last1, 1'b1);
    tick();
    check("t6_after", resp_valid1, 1'b0);

    // randomized traffic against the model
    acc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc = req_valid && req_ready && rst_ni;
      tick();
      rst_ni = ($urandom_range(0, 599) != 0);
      resp_ready = ($urandom_range(0, 9) < 7);
      bd_we = ($urandom_range(0, 4) == 0);
      bd_addr = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 18)) : 10'($urandom_range(1016, 1023));
      bd_data = {$urandom, $urandom};
      if (!req_valid || acc) begin
        if ($urandom_range(0, 9) < 4) begin
          req_valid = 1'b1;
          req_addr = (($urandom_range(0, 2) != 0) ? 64'($urandom_range(0, 15)) : 64'($urandom_range(1018, 1023))) * 8
                     + 64'($urandom_range(0, 7));
          req_tid = 4'($urandom_range(0, 15));
          req_len = 2'($urandom_range(0, 3));
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rst_ni = 1'b1;
    req_valid = 1'b0;
    bd_we = 1'b0;
    resp_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
